// File: rtl/sync_debounce_if.sv
// Purpose: groups the per-channel data signals of sync_debounce.
//   direct_in    : raw asynchronous levels driven by the source
//   filtered_out : synchronised, debounced level per channel
//   rise_pulse   : one-cycle strobe when filtered_out[i] goes 0->1
//   fall_pulse   : one-cycle strobe when filtered_out[i] goes 1->0
// master drives direct_in and observes the results; slave is the debouncer.
interface sync_debounce_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] direct_in;
  logic [WIDTH-1:0] filtered_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;

  modport master (
    output direct_in,
    input  filtered_out,
    input  rise_pulse,
    input  fall_pulse
  );

  modport slave (
    input  direct_in,
    output filtered_out,
    output rise_pulse,
    output fall_pulse
  );
endinterface

// File: rtl/sync_debounce.sv
// Purpose: per-channel synchroniser + debounce filter with edge strobes.
// Ports:
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous, active-high; preloads every stage with direct_in
//   bus   : sync_debounce_if.slave (direct_in in; filtered_out,
//           rise_pulse, fall_pulse out, all registered)
// A level first sampled at edge k and held appears on filtered_out at edge
// k + SYNC_STAGES + DEBOUNCE_CYCLES - 1.
module sync_debounce #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  sync_debounce_if.slave    bus
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Refuse illegal configurations at elaboration.
  if (WIDTH < 1 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("sync_debounce: need WIDTH>=1, SYNC_STAGES>=2, DEBOUNCE_CYCLES>=1");
  end

  logic [WIDTH-1:0] filt_vec;
  logic [WIDTH-1:0] rise_vec;
  logic [WIDTH-1:0] fall_vec;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   filt_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   synced_c;
    logic                   mismatch_c;
    logic                   accept_c;

    // Last synchroniser stage is the only one the filter may look at.
    assign synced_c   = sync_q[SYNC_STAGES-1];
    assign mismatch_c = (synced_c != filt_q);
    // Accept on the DEBOUNCE_CYCLES-th consecutive mismatching edge.
    assign accept_c   = mismatch_c && (cnt_q == CNT_LAST);

    // Synchroniser chain, debounce counter, filtered level and strobes.
    always_ff @(posedge clk) begin
      if (reset) begin
        // Preload with the live input so nothing looks like a change after reset.
        sync_q <= {SYNC_STAGES{bus.direct_in[i]}};
        filt_q <= bus.direct_in[i];
        cnt_q  <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.direct_in[i]};
        rise_q <= accept_c & synced_c;
        fall_q <= accept_c & ~synced_c;
        // Any agreeing edge discards a partial count; a completed count restarts.
        if (!mismatch_c || accept_c) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        if (accept_c) begin
          filt_q <= synced_c;
        end
      end
    end

    assign filt_vec[i] = filt_q;
    assign rise_vec[i] = rise_q;
    assign fall_vec[i] = fall_q;
  end

  assign bus.filtered_out = filt_vec;
  assign bus.rise_pulse   = rise_vec;
  assign bus.fall_pulse   = fall_vec;

endmodule

// File: tb/tb_sync_debounce.sv
module tb_sync_debounce;

  localparam int unsigned W = 4;

  typedef struct {
    logic         rst;
    logic [W-1:0] din;
    logic [W-1:0] exp_f;
    logic [W-1:0] exp_r;
    logic [W-1:0] exp_fl;
    int           tag;
  } vec_t;

  typedef struct {
    logic [W-1:0] f;
    logic [W-1:0] r;
    logic [W-1:0] fl;
    int           tag;
  } exp_t;

  logic clk;
  logic reset;

  sync_debounce_if #(.WIDTH(W)) bus ();

  sync_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Append n identical cycles to the vector table.
  task automatic add(input logic rst, input logic [W-1:0] din,
                     input logic [W-1:0] f, input logic [W-1:0] r,
                     input logic [W-1:0] fl, input int n, input int tag);
    vec_t v;
    v.rst = rst; v.din = din; v.exp_f = f; v.exp_r = r; v.exp_fl = fl; v.tag = tag;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int tag, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (REQ-%0d) t=%0t: got %b, expected %b", name, tag, $time, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, push expectation, compare after the rising edge.
  task automatic step(input vec_t v);
    exp_t e;
    exp_t got;
    reset         = v.rst;
    bus.direct_in = v.din;
    e.f = v.exp_f; e.r = v.exp_r; e.fl = v.exp_fl; e.tag = v.tag;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
    end else begin
      got = exp_q.pop_front();
      chk("filtered_out", got.tag, bus.filtered_out, got.f);
      chk("rise_pulse",   got.tag, bus.rise_pulse,   got.r);
      chk("fall_pulse",   got.tag, bus.fall_pulse,   got.fl);
      chk("rise_and_fall_overlap", 18, bus.rise_pulse & bus.fall_pulse, '0);
    end
  endtask

  task automatic cyc(input logic rst, input logic [W-1:0] din,
                     input logic [W-1:0] f, input logic [W-1:0] r,
                     input logic [W-1:0] fl, input int tag);
    vec_t v;
    v.rst = rst; v.din = din; v.exp_f = f; v.exp_r = r; v.exp_fl = fl; v.tag = tag;
    step(v);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b1;
    bus.direct_in = '0;
    @(negedge clk);

    // Reset loads direct_in straight into filtered_out, no pulses after it.
    add(1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 1, 25);
    add(1'b0, 4'b1010, 4'b1010, 4'b0000, 4'b0000, 3, 24);
    // Single rise on ch0: visible at edge k+5 with a one-cycle strobe.
    add(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 26);
    add(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 5, 26);
    add(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1, 26);
    add(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 2, 26);
    // 3-cycle glitch on ch1 is discarded.
    add(1'b0, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 3, 27);
    add(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 8, 27);
    // Simultaneous rise ch0 / fall ch3.
    add(1'b1, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1, 28);
    add(1'b0, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 5, 28);
    add(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b1000, 1, 28);
    add(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 2, 28);
    // Fall on ch0 alongside rises on ch1..3.
    add(1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 5, 19);
    add(1'b0, 4'b1110, 4'b1110, 4'b1110, 4'b0001, 1, 19);
    add(1'b0, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 2, 19);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Reset while ch2 count is at 2: reset-time input wins, no strobe.
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 29);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 29);
    cyc(1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 29);
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 29);

    // Reset mid-count with the input already back at the old level: count lost.
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 23);
    cyc(1'b1, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 23);
    for (int i = 0; i < 6; i++) cyc(1'b0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 23);

    // ch0 toggles for 10 cycles then holds 1: exactly one rise, 5 edges later.
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 30);
    for (int i = 0; i < 10; i++)
      cyc(1'b0, (i % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0000, 4'b0000, 4'b0000, 30);
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 30);
    cyc(1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 30);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 30);

    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 The module SHALL have a parameter WIDTH, default 1, giving the number of independent input channels (>=1).
REQ-002 The module SHALL have a parameter SYNC_STAGES, default 2, giving the number of synchroniser flops per channel (>=2).
REQ-003 The module SHALL have a parameter DEBOUNCE_CYCLES, default 1, giving the number of consecutive mismatching cycles required to accept a change (>=1).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-006 The module SHALL have port direct_in, input, WIDTH bits: raw asynchronous inputs.
REQ-007 The module SHALL have port filtered_out, output, WIDTH bits: synchronised, debounced level per channel.
REQ-008 The module SHALL have port rise_pulse, output, WIDTH bits: one-cycle strobe when filtered_out[i] goes 0->1.
REQ-009 The module SHALL have port fall_pulse, output, WIDTH bits: one-cycle strobe when filtered_out[i] goes 1->0.

Function
REQ-010 Each channel SHALL pass direct_in[i] through a chain of SYNC_STAGES flops; synced[i] is the last stage; no logic between stages.
REQ-011 Each channel SHALL hold a debounce counter of max(1, $clog2(DEBOUNCE_CYCLES)) bits.
REQ-012 At each edge, when synced[i] == filtered_out[i], the counter SHALL clear to 0 and filtered_out[i] SHALL hold.
REQ-013 At each edge, when synced[i] != filtered_out[i] and counter < DEBOUNCE_CYCLES-1, the counter SHALL increment by 1 and filtered_out[i] SHALL hold.
REQ-014 At each edge, when synced[i] != filtered_out[i] and counter == DEBOUNCE_CYCLES-1, filtered_out[i] SHALL load synced[i] and the counter SHALL clear to 0.
REQ-015 A mismatch lasting fewer than DEBOUNCE_CYCLES consecutive edges SHALL be discarded: counter returns to 0, no output change, no pulse.
REQ-016 Latency: a direct_in[i] level first sampled at edge k and held stable SHALL appear on filtered_out[i] at edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1, exactly.
REQ-017 rise_pulse[i] / fall_pulse[i] SHALL be registered and high for exactly the one cycle in which filtered_out[i] holds its new value; at all other times they SHALL be 0.
REQ-018 rise_pulse[i] and fall_pulse[i] SHALL never be high in the same cycle.
REQ-019 Channels SHALL be fully independent; simultaneous transitions on any set of channels SHALL each be handled per REQ-012..REQ-017 in the same cycle.
REQ-020 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and never wrap.
REQ-021 The module SHALL reject SYNC_STAGES<2, DEBOUNCE_CYCLES<1 or WIDTH<1 at elaboration.

Reset
REQ-022 On an edge with reset=1, every synchroniser stage and filtered_out SHALL load the current direct_in, all counters SHALL clear to 0, and rise_pulse/fall_pulse SHALL be 0.
REQ-023 Reset SHALL take priority over in-progress debounce counts; a partial count SHALL be discarded without a pulse.
REQ-024 No pulse SHALL be generated on the first edge after reset deasserts unless REQ-014 is met by post-reset inputs.

Verification (WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
REQ-025 Reset with direct_in=4'b1010 for one edge -> filtered_out=4'b1010, rise_pulse=fall_pulse=4'b0000 after that edge.
REQ-026 From filtered_out=4'b0000, direct_in[0] 0->1 before edge k, held -> filtered_out[0]=1 from edge k+5; rise_pulse[0]=1 only in cycle after edge k+5; fall_pulse=0 throughout.
REQ-027 direct_in[1] high for 3 cycles then low -> filtered_out[1] stays 0, no pulses on any channel.
REQ-028 direct_in[0] 0->1 and direct_in[3] 1->0 at same edge -> both change at edge k+5; rise_pulse=4'b0001 and fall_pulse=4'b1000 in the same single cycle.
REQ-029 direct_in[2] 0->1; assert reset when its counter=2 -> filtered_out[2]=1 (reset-time direct_in), counter 0, no rise_pulse during or after reset.
REQ-030 direct_in[0] toggles every cycle for 10 cycles then holds 1 -> exactly one transition of filtered_out[0] and one rise_pulse[0], 5 edges after the final stable sample.
